demo_scene_sequencer: RTL and testbench

- Frame-locked scheduler for the demoscene top level. Steps through a constant scene table and drives the VGA pattern select (vga_state), the audio source select (audio_select) and the PWM sample/volume byte.
- Sits between the SPI slave's received-byte stream and the vga/audio_source/pwm instances.
- SPI commands can jump to a scene, hold the current scene, or set the volume. All changes take effect only on a frame boundary, so the display never tears mid-frame.

---
 rtl/demo_pkg.sv | 68 ++++++
 rtl/demo_spi_cmd_parser.sv | 48 ++++
 rtl/demo_scene_sequencer.sv | 147 ++++++++++++++
 tb/tb_demo_scene_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demo_pkg.sv
// Shared opcodes, FSM encodings and the constant scene table for the demo scene sequencer.
package demo_pkg;

    localparam logic [7:0] OP_GOTO = 8'h01;
    localparam logic [7:0] OP_HOLD = 8'h02;
    localparam logic [7:0] OP_VOL  = 8'h03;

    localparam int VGA_W   = 3;
    localparam int AUDIO_W = 2;
    localparam int DUR_W   = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_PLAY,
        SEQ_HOLD
    } seq_state_t;

    typedef enum logic {
        PARSE_CMD,
        PARSE_ARG
    } parse_state_t;

    typedef struct packed {
        logic [VGA_W-1:0]   vga;
        logic [AUDIO_W-1:0] audio;
        logic [DUR_W-1:0]   duration;
    } scene_entry_t;

    localparam int SCENE_TABLE_LEN = 8;

    // Entry 3 deliberately has duration 0, which plays as a single frame.
    localparam scene_entry_t SCENE_TABLE [SCENE_TABLE_LEN] = '{
        {3'd1, 2'd1, 8'd3},
        {3'd2, 2'd2, 8'd2},
        {3'd3, 2'd3, 8'd4},
        {3'd4, 2'd0, 8'd0},
        {3'd5, 2'd1, 8'd1},
        {3'd6, 2'd2, 8'd8},
        {3'd7, 2'd3, 8'd5},
        {3'd0, 2'd0, 8'd2}
    };

    function automatic scene_entry_t scene_lookup(input logic [7:0] idx);
        scene_entry_t entry;
        entry = {3'd0, 2'd0, 8'd1};
        if (idx < 8'(SCENE_TABLE_LEN)) entry = SCENE_TABLE[idx[2:0]];
        return entry;
    endfunction

    function automatic logic [VGA_W-1:0] scene_vga(input logic [7:0] idx);
        scene_entry_t entry;
        entry = scene_lookup(idx);
        return entry.vga;
    endfunction

    function automatic logic [AUDIO_W-1:0] scene_audio(input logic [7:0] idx);
        scene_entry_t entry;
        entry = scene_lookup(idx);
        return entry.audio;
    endfunction

    function automatic logic [DUR_W-1:0] scene_duration(input logic [7:0] idx);
        scene_entry_t entry;
        entry = scene_lookup(idx);
        return (entry.duration == '0) ? DUR_W'(1) : entry.duration;
    endfunction

endpackage

// File: rtl/demo_spi_cmd_parser.sv
// Two-byte SPI command parser: opcode byte then argument byte, decoded into one-cycle strobes.
module demo_spi_cmd_parser
    import demo_pkg::*;
#(
    parameter int NUM_SCENES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_byte_valid,
    input  logic [7:0] spi_byte,
    output logic       goto_valid,
    output logic [7:0] goto_idx,
    output logic       hold_valid,
    output logic       hold_val,
    output logic       vol_valid,
    output logic [7:0] vol_val
);

    localparam logic [8:0] SCENE_LIMIT = 9'(NUM_SCENES);

    parse_state_t state;
    logic [7:0]   opcode;
    logic         exec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= PARSE_CMD;
            opcode <= 8'h00;
        end else if (spi_byte_valid) begin
            if (state == PARSE_CMD) begin
                opcode <= spi_byte;
                state  <= PARSE_ARG;
            end else begin
                state  <= PARSE_CMD;
            end
        end
    end

    // Strobes are combinational so the sequencer registers them on the argument byte's own edge.
    assign exec       = (state == PARSE_ARG) && spi_byte_valid;
    assign goto_valid = exec && (opcode == OP_GOTO) && ({1'b0, spi_byte} < SCENE_LIMIT);
    assign goto_idx   = spi_byte;
    assign hold_valid = exec && (opcode == OP_HOLD);
    assign hold_val   = spi_byte[0];
    assign vol_valid  = exec && (opcode == OP_VOL);
    assign vol_val    = spi_byte;

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-locked scene scheduler driving VGA pattern, audio source and PWM byte.
// Optional end-of-scene volume fade is enabled by defining SCENE_FADE_EN.
module demo_scene_sequencer
    import demo_pkg::*;
#(
    parameter int         NUM_SCENES  = 8,
    parameter logic [7:0] VOL_RESET   = 8'h80,
    parameter int         FADE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       spi_byte_valid,
    input  logic [7:0] spi_byte,
    output logic [2:0] vga_state,
    output logic [1:0] audio_select,
    output logic [7:0] sample,
    output logic [7:0] scene_idx,
    output logic       held
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_SCENES - 1);

    if (NUM_SCENES < 1 || NUM_SCENES > 256 || FADE_FRAMES < 1) begin : g_param_check
        $error("demo_scene_sequencer: parameter out of range");
    end

    seq_state_t state;
    logic [7:0] frame_cnt;
    logic       pending_goto;
    logic [7:0] pending_idx;
    logic [7:0] volume;

    logic       goto_valid, hold_valid, hold_val, vol_valid;
    logic [7:0] goto_idx, vol_val;

    logic [7:0] cur_dur;
    logic       load_scene;
    logic [7:0] load_idx;
    logic [7:0] next_cnt;
    logic [7:0] next_sample;

    demo_spi_cmd_parser #(.NUM_SCENES(NUM_SCENES)) u_parser (
        .clk            (clk),
        .rst            (rst),
        .spi_byte_valid (spi_byte_valid),
        .spi_byte       (spi_byte),
        .goto_valid     (goto_valid),
        .goto_idx       (goto_idx),
        .hold_valid     (hold_valid),
        .hold_val       (hold_val),
        .vol_valid      (vol_valid),
        .vol_val        (vol_val)
    );

    assign cur_dur = scene_duration(scene_idx);

    // What the next frame boundary would do; a pending goto always beats natural advance.
    always_comb begin
        load_scene = 1'b0;
        load_idx   = scene_idx;
        next_cnt   = frame_cnt;
        case (state)
            SEQ_IDLE: begin
                load_scene = 1'b1;
                load_idx   = pending_goto ? pending_idx : 8'd0;
            end
            SEQ_PLAY: begin
                if (pending_goto) begin
                    load_scene = 1'b1;
                    load_idx   = pending_idx;
                end else if (frame_cnt == cur_dur - 8'd1) begin
                    load_scene = 1'b1;
                    load_idx   = (scene_idx == LAST_IDX) ? 8'd0 : scene_idx + 8'd1;
                end else begin
                    next_cnt = frame_cnt + 8'd1;
                end
            end
            SEQ_HOLD: begin
                if (pending_goto) begin
                    load_scene = 1'b1;
                    load_idx   = pending_idx;
                end
            end
            default: ;
        endcase
        if (load_scene) next_cnt = 8'd0;
    end

`ifdef SCENE_FADE_EN
    logic [7:0] next_dur;
    int         fade_start;

    always_comb begin
        next_sample = volume;
        next_dur    = scene_duration(load_idx);
        fade_start  = int'(next_dur) - FADE_FRAMES;
        if (state == SEQ_PLAY && int'(next_dur) > FADE_FRAMES && int'(next_cnt) >= fade_start)
            next_sample = volume >> (int'(next_cnt) - fade_start + 1);
    end
`else
    assign next_sample = volume;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SEQ_IDLE;
            frame_cnt    <= 8'd0;
            pending_goto <= 1'b0;
            pending_idx  <= 8'd0;
            volume       <= VOL_RESET;
            vga_state    <= 3'd0;
            audio_select <= 2'd0;
            sample       <= VOL_RESET;
            scene_idx    <= 8'd0;
            held         <= 1'b0;
        end else begin
            if (frame_start) begin
                if (load_scene) begin
                    scene_idx    <= load_idx;
                    vga_state    <= scene_vga(load_idx);
                    audio_select <= scene_audio(load_idx);
                end
                frame_cnt    <= next_cnt;
                sample       <= next_sample;
                pending_goto <= 1'b0;
                if (state == SEQ_IDLE) state <= SEQ_PLAY;
            end
            // A goto landing on a boundary edge must survive to the following boundary.
            if (goto_valid) begin
                pending_goto <= 1'b1;
                pending_idx  <= goto_idx;
            end
            if (vol_valid) volume <= vol_val;
            if (hold_valid) begin
                if (state == SEQ_PLAY && hold_val) begin
                    state <= SEQ_HOLD;
                    held  <= 1'b1;
                end else if (state == SEQ_HOLD && !hold_val) begin
                    state <= SEQ_PLAY;
                    held  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Self-checking bench for demo_scene_sequencer: directed scenarios then randomized traffic vs a frame-level model.
module tb_demo_scene_sequencer;

    localparam int         NUM  = 8;
    localparam logic [7:0] VOLR = 8'h80;
    localparam int         FADE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       spi_byte_valid = 1'b0;
    logic [7:0] spi_byte = 8'h00;
    logic [2:0] vga_state;
    logic [1:0] audio_select;
    logic [7:0] sample;
    logic [7:0] scene_idx;
    logic       held;

    int n_cmp = 0;
    int n_err = 0;

    int tbl_vga [NUM] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int tbl_aud [NUM] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int tbl_dur [NUM] = '{3, 2, 4, 0, 1, 8, 5, 2};

    bit m_started, m_held;
    int m_idx, m_cnt, m_pend, m_vol, m_sample, m_op;

    demo_scene_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .spi_byte_valid (spi_byte_valid),
        .spi_byte       (spi_byte),
        .vga_state      (vga_state),
        .audio_select   (audio_select),
        .sample         (sample),
        .scene_idx      (scene_idx),
        .held           (held)
    );

    always #5 clk = ~clk;

    task checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int durOf(input int idx);
        return (tbl_dur[idx] == 0) ? 1 : tbl_dur[idx];
    endfunction

    task modelReset();
        m_started = 0; m_held = 0; m_idx = 0; m_cnt = 0;
        m_pend = -1; m_vol = VOLR; m_sample = VOLR; m_op = -1;
    endtask

    // One clock edge of the model, evaluated from the pre-edge state.
    task modelEdge(input bit fs, input bit bv, input int b);
        bit was_started, was_playing;
        was_started = m_started;
        was_playing = m_started && !m_held;
        if (fs) begin
            if (m_pend >= 0) begin
                m_idx = m_pend; m_cnt = 0;
            end else if (!m_started) begin
                m_idx = 0; m_cnt = 0;
            end else if (!m_held) begin
                if (m_cnt + 1 >= durOf(m_idx)) begin
                    m_idx = (m_idx + 1) % NUM; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            m_started = 1;
            m_pend = -1;
            m_sample = m_vol;
`ifdef SCENE_FADE_EN
            if (was_playing && durOf(m_idx) > FADE && m_cnt >= durOf(m_idx) - FADE)
                m_sample = m_vol >> (m_cnt - (durOf(m_idx) - FADE) + 1);
`endif
        end
        if (bv) begin
            if (m_op < 0) begin
                m_op = b;
            end else begin
                if (m_op == 1 && b < NUM) m_pend = b;
                if (m_op == 2 && was_started) m_held = b[0];
                if (m_op == 3) m_vol = b;
                m_op = -1;
            end
        end
        if (was_playing && 0) m_op = m_op;
    endtask

    task compareModel(input string tag);
        int v, a;
        v = m_started ? tbl_vga[m_idx] : 0;
        a = m_started ? tbl_aud[m_idx] : 0;
        checkOutput({tag, " vga_state"},    {5'b0, vga_state},    8'(v));
        checkOutput({tag, " audio_select"}, {6'b0, audio_select}, 8'(a));
        checkOutput({tag, " sample"},       sample,               8'(m_sample));
        checkOutput({tag, " scene_idx"},    scene_idx,            8'(m_idx));
        checkOutput({tag, " held"},         {7'b0, held},         {7'b0, m_held});
    endtask

    // Called #1 after a rising edge; drives inputs for the next edge and checks the result.
    task applyStimulus(input string tag, input bit fs, input bit bv, input logic [7:0] b);
        frame_start = fs; spi_byte_valid = bv; spi_byte = b;
        @(posedge clk);
        modelEdge(fs, bv, int'(b));
        #1;
        frame_start = 1'b0; spi_byte_valid = 1'b0;
        compareModel(tag);
    endtask

    task pulseReset();
        frame_start = 1'b0; spi_byte_valid = 1'b0;
        rst = 1'b1;
        #2;
        modelReset();
        compareModel("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task frame(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 8'h00);
    endtask

    task sendByte(input string tag, input logic [7:0] b);
        applyStimulus(tag, 1'b0, 1'b1, b);
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus("idle", 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int guard;
        logic [7:0] rb;
        modelReset();
        @(posedge clk);
        #1;
        pulseReset();

        checkOutput("reset vga_state", {5'b0, vga_state}, 8'h00);
        checkOutput("reset sample", sample, 8'h80);
        checkOutput("reset held", {7'b0, held}, 8'h00);
        idle(3);
        frame("first_frame");
        checkOutput("first vga_state", {5'b0, vga_state}, 8'h01);
        checkOutput("first audio_select", {6'b0, audio_select}, 8'h01);
        checkOutput("first scene_idx", scene_idx, 8'h00);

        frame("adv"); frame("adv");
        checkOutput("no early advance", scene_idx, 8'h00);
        frame("adv");
        checkOutput("advance to 1", scene_idx, 8'h01);

        guard = 0;
        while (m_idx != 7 && guard < 60) begin
            frame("walk");
            guard++;
        end
        if (guard >= 60) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL walk_budget: got %0d frames, expected fewer than 60", guard);
        end
        frame("wrap"); frame("wrap");
        checkOutput("wrap to 0", scene_idx, 8'h00);

        sendByte("goto_op", 8'h01); idle(2); sendByte("goto_arg", 8'h05); idle(3);
        checkOutput("goto before boundary", scene_idx, 8'h00);
        frame("goto_apply");
        checkOutput("goto applied", scene_idx, 8'h05);
        sendByte("bad_goto", 8'h01); sendByte("bad_goto", 8'hFF); frame("bad_goto");
        checkOutput("out of range goto ignored", scene_idx, 8'h05);

        sendByte("hold_op", 8'h02); sendByte("hold_arg", 8'h01);
        checkOutput("held set", {7'b0, held}, 8'h01);
        for (int i = 0; i < 20; i++) begin
            frame("hold");
            checkOutput("hold keeps scene", scene_idx, 8'h05);
        end
        sendByte("hold_goto", 8'h01); sendByte("hold_goto", 8'h02); frame("hold_goto");
        checkOutput("goto while held", scene_idx, 8'h02);
        sendByte("run_op", 8'h02); sendByte("run_arg", 8'h00);
        checkOutput("held cleared", {7'b0, held}, 8'h00);
        for (int i = 0; i < 4; i++) frame("resume");
        checkOutput("advance resumes", scene_idx, 8'h03);

        sendByte("vol_op", 8'h03);
        applyStimulus("vol_coincident", 1'b1, 1'b1, 8'h40);
        checkOutput("vol not yet", sample, 8'h80);
        frame("vol_apply");
        checkOutput("vol applied", sample, 8'h40);
        sendByte("unknown_op", 8'h7E); sendByte("unknown_arg", 8'h11); frame("unknown");

        sendByte("half_cmd", 8'h01);
        pulseReset();
        sendByte("vol_op2", 8'h03); sendByte("vol_arg2", 8'h20); frame("vol_after_reset");
        checkOutput("no stale opcode", sample, 8'h20);

        pulseReset();
        sendByte("idle_goto", 8'h01); sendByte("idle_goto", 8'h04); frame("idle_goto");
        checkOutput("idle goto scene_idx", scene_idx, 8'h04);
        checkOutput("idle goto vga_state", {5'b0, vga_state}, 8'h05);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                pulseReset();
            end else begin
                if (m_op < 0) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: rb = 8'h01;
                        4, 5:       rb = 8'h02;
                        6, 7:       rb = 8'h03;
                        default:    rb = 8'($urandom_range(0, 255));
                    endcase
                end else if (m_op == 2) begin
                    rb = {7'($urandom_range(0, 127)), ($urandom_range(0, 2) == 0)};
                end else if ($urandom_range(0, 3) == 0) begin
                    rb = 8'($urandom_range(0, 255));
                end else begin
                    rb = 8'($urandom_range(0, 9));
                end
                applyStimulus("random", ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), rb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
